// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: FSM state encoding,
// condition-flag index constants and default sizing.
// No ports.
package branch_resolve_unit_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESOLVE = 1'b1
    } state_e;

    // Selects 0..3 keep the meaning of the legacy 2-bit branch_ctrl field.
    localparam int COND_GT     = 0;
    localparam int COND_NOT_GT = 1;
    localparam int COND_NOT_EQ = 2;
    localparam int COND_EQ     = 3;
    localparam int COND_LT     = 4;
    localparam int COND_OVF    = 5;
    localparam int COND_ZERO   = 6;
    localparam int COND_NEG    = 7;

    localparam int DEF_NUM_COND = 8;
    localparam int DEF_SEL_W    = 3;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between the control FSM / ALU (master) and the branch resolve unit (slave).
//   master drives: flags_in, flags_we, branch_req, branch_ctrl, invert,
//                  pc_write, cnt_clear
//   slave drives : ready, branch_done, branch_taken, pc_write_en, flags_q,
//                  sel_err, resolved_cnt, taken_cnt
interface branch_resolve_unit_if #(
    parameter int NUM_COND = 8,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 16
) ();
    logic [NUM_COND-1:0] flags_in;
    logic                flags_we;
    logic                branch_req;
    logic [SEL_W-1:0]    branch_ctrl;
    logic                invert;
    logic                pc_write;
    logic                cnt_clear;

    logic                ready;
    logic                branch_done;
    logic                branch_taken;
    logic                pc_write_en;
    logic [NUM_COND-1:0] flags_q;
    logic                sel_err;
    logic [CNT_W-1:0]    resolved_cnt;
    logic [CNT_W-1:0]    taken_cnt;

    modport master (
        output flags_in, flags_we, branch_req, branch_ctrl, invert, pc_write, cnt_clear,
        input  ready, branch_done, branch_taken, pc_write_en, flags_q, sel_err,
               resolved_cnt, taken_cnt
    );

    modport slave (
        input  flags_in, flags_we, branch_req, branch_ctrl, invert, pc_write, cnt_clear,
        output ready, branch_done, branch_taken, pc_write_en, flags_q, sel_err,
               resolved_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit_sat.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, async active-low reset
//   inc_i         : increment by one (holds at all-ones)
//   clr_i         : synchronous clear, wins over inc_i
//   count_o       : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registered condition-flag bank, two-state req/done
// resolution of conditional branches, combinational pass-through of
// unconditional PC writes, and saturating resolved/taken statistics.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   br_if  : slave side of branch_resolve_unit_if (all data/handshake signals)
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int NUM_COND = DEF_NUM_COND,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    branch_resolve_unit_if.slave  br_if
);
    state_e              state_q, state_d;
    logic [NUM_COND-1:0] flags_q;
    logic [SEL_W-1:0]    sel_q;
    logic                inv_q;
    logic                sel_err_q;

    logic ready, done, latch_en;
    logic cond, sel_oor, taken;

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        done     = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (br_if.branch_req) begin
                    latch_en = 1'b1;
                    state_d  = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Match the latched select against every implemented flag; a select with
    // no matching flag is out of range and resolves as cond=0.
    always_comb begin
        cond    = 1'b0;
        sel_oor = 1'b1;
        for (int i = 0; i < NUM_COND; i++) begin
            if (sel_q == i[SEL_W-1:0]) begin
                cond    = flags_q[i];
                sel_oor = 1'b0;
            end
        end
    end

    assign taken = done & (cond ^ inv_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            flags_q   <= '0;
            sel_q     <= '0;
            inv_q     <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (br_if.flags_we) flags_q <= br_if.flags_in;
            if (latch_en) begin
                sel_q <= br_if.branch_ctrl;
                inv_q <= br_if.invert;
            end
            if (done && sel_oor) sel_err_q <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_resolved_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (done),
        .clr_i   (br_if.cnt_clear),
        .count_o (br_if.resolved_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (taken),
        .clr_i   (br_if.cnt_clear),
        .count_o (br_if.taken_cnt)
    );

    assign br_if.ready        = ready;
    assign br_if.branch_done  = done;
    assign br_if.branch_taken = taken;
    assign br_if.pc_write_en  = br_if.pc_write | taken;
    assign br_if.flags_q      = flags_q;
    assign br_if.sel_err      = sel_err_q;
endmodule
